// File: rtl/mesi_pkg.sv
// mesi_pkg: bus packet layout, transaction ids and FSM states shared by the snoop bus
// Packet layout (MSB..LSB): {pid[1:0], tid[2:0], tag[1:0], idx[1:0], data[Cache_Block_Size-1:0]}
package mesi_pkg;
  localparam int Cache_Block_Size = 8;
  localparam int MEM_DEPTH = 16;
  localparam int PID_W = 2;
  localparam int TID_W = 3;
  localparam int TAG_W = 2;
  localparam int IDX_W = 2;
  localparam int ADDR_W = TAG_W + IDX_W;
  localparam int BUS_W = 9 + Cache_Block_Size;
  localparam int DATA_LSB = 0;
  localparam int IDX_LSB = Cache_Block_Size;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TID_LSB = TAG_LSB + TAG_W;
  localparam int PID_LSB = TID_LSB + TID_W;
  typedef enum logic [TID_W-1:0] {
    NOOP     = 3'd0,
    BUSRD    = 3'd1,
    BUSRDX   = 3'd2,
    BUSUPGR  = 3'd3,
    FLUSH    = 3'd4,
    FLUSHOPT = 3'd5,
    MEMDATA  = 3'd6,
    SHARED   = 3'd7
  } bus_tid_e;
  typedef enum logic [1:0] {SB_IDLE, SB_BCAST, SB_SNOOP, SB_RESP} sb_state_e;
  function automatic logic [BUS_W-1:0] pack_pkt(input logic [PID_W-1:0] pid, input bus_tid_e tid,
                                                input logic [ADDR_W-1:0] addr,
                                                input logic [Cache_Block_Size-1:0] data);
    return {pid, tid, addr, data};
  endfunction
endpackage

// File: rtl/mesi_rr_arbiter.sv
// mesi_rr_arbiter: N-way round-robin arbiter, first request at or after the pointer wins
// Ports: req (request vector), accept (winner taken this cycle, advances pointer),
//        gnt (one-hot winner), idx (winner index)
module mesi_rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  logic [W-1:0] ptr, j;
  logic found;
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = W'((int'(ptr) + k) % N);
      if (!found && req[j]) begin
        found = 1'b1;
        idx = j;
        gnt[j] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ptr <= '0;
    else if (accept) ptr <= (idx == W'(N - 1)) ? '0 : idx + 1'b1;
  end
endmodule

// File: rtl/mesi_snoop_bus.sv
// mesi_snoop_bus: round-robin snooping interconnect with backing memory for MESI cores
// Ports: req_flag/req_bus/req_gnt (core requests and one-cycle grant), bcast_flag/bcast_bus
//        (granted packet to all cores), snp_flag/snp_bus (snoop replies), rsp_flag/rsp_bus/rsp_shared
//        (response to requester; rsp_shared selects S over E on install)
module mesi_snoop_bus
  import mesi_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int SNOOP_WIN = 2
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [N_CORES-1:0]              req_flag,
  input  logic [N_CORES-1:0][BUS_W-1:0]   req_bus,
  output logic [N_CORES-1:0]              req_gnt,
  output logic                            bcast_flag,
  output logic [BUS_W-1:0]                bcast_bus,
  input  logic [N_CORES-1:0]              snp_flag,
  input  logic [N_CORES-1:0][BUS_W-1:0]   snp_bus,
  output logic                            rsp_flag,
  output logic [BUS_W-1:0]                rsp_bus,
  output logic                            rsp_shared
);
  localparam int NW = $clog2(N_CORES);
  localparam int CW = $clog2(SNOOP_WIN + 1);
  sb_state_e state, state_nx;
  bus_tid_e req_tid, rsp_tid;
  logic [BUS_W-1:0] pkt;
  logic [NW-1:0] req_id, win;
  logic [N_CORES-1:0] arb_gnt;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] addr;
  logic accept, last_snoop, fl_valid, shared_seen, hit, hit_flush, hit_shared, unused_snp;
  logic [Cache_Block_Size-1:0] fl_data, hit_data, rd_data, rsp_data;
  logic [Cache_Block_Size-1:0] mem [MEM_DEPTH];
  assign req_tid = bus_tid_e'(pkt[TID_LSB +: TID_W]);
  assign addr = pkt[IDX_LSB +: ADDR_W];
  // grant is combinational so a core sees it in the cycle its request is taken; gated off during reset
  assign accept = resetn && state == SB_IDLE && |req_flag;
  assign last_snoop = cnt == CW'(SNOOP_WIN - 1);
  // reply address/pid fields are informational; the request address is authoritative
  assign unused_snp = ^snp_bus;
  mesi_rr_arbiter #(.N(N_CORES)) u_arb (
    .clk(clk),
    .resetn(resetn),
    .req(req_flag),
    .accept(accept),
    .gnt(arb_gnt),
    .idx(win)
  );
  assign req_gnt = accept ? arb_gnt : '0;
  // lowest-index data reply wins within a cycle; the requester's own reply is ignored
  always_comb begin
    hit = 1'b0;
    hit_flush = 1'b0;
    hit_shared = 1'b0;
    hit_data = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (state == SB_SNOOP && snp_flag[i] && NW'(i) != req_id) begin
        if (snp_bus[i][TID_LSB +: TID_W] == FLUSH || snp_bus[i][TID_LSB +: TID_W] == FLUSHOPT) begin
          if (!hit) begin
            hit = 1'b1;
            hit_flush = snp_bus[i][TID_LSB +: TID_W] == FLUSH;
            hit_data = snp_bus[i][DATA_LSB +: Cache_Block_Size];
          end
          hit_shared = 1'b1;
        end else if (snp_bus[i][TID_LSB +: TID_W] == SHARED) begin
          hit_shared = 1'b1;
        end
      end
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      SB_IDLE:  state_nx = accept ? SB_BCAST : SB_IDLE;
      SB_BCAST: state_nx = SB_SNOOP;
      SB_SNOOP: state_nx = last_snoop ? SB_RESP : SB_SNOOP;
      default:  state_nx = SB_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= SB_IDLE;
      pkt <= '0;
      req_id <= '0;
      cnt <= '0;
      fl_valid <= 1'b0;
      fl_data <= '0;
      shared_seen <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        pkt <= req_bus[win];
        req_id <= win;
        cnt <= '0;
        fl_valid <= 1'b0;
        shared_seen <= 1'b0;
      end
      if (state == SB_SNOOP) begin
        cnt <= cnt + 1'b1;
        if (hit && !fl_valid) begin
          fl_valid <= 1'b1;
          fl_data <= hit_data;
        end
        if (hit_shared) shared_seen <= 1'b1;
      end
    end
  end
  // eviction writeback lands in the first snoop cycle; a flushing sharer's data overrides it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int a = 0; a < MEM_DEPTH; a++) mem[a] <= '1;
    end else if (state == SB_SNOOP) begin
      if (hit_flush) mem[addr] <= hit_data;
      else if (cnt == '0 && req_tid == FLUSH) mem[addr] <= pkt[DATA_LSB +: Cache_Block_Size];
    end
  end
  assign rd_data = fl_valid ? fl_data : mem[addr];
  always_comb begin
    rsp_tid = NOOP;
    rsp_data = '0;
    case (req_tid)
      BUSRD, BUSRDX: begin
        rsp_tid = MEMDATA;
        rsp_data = rd_data;
      end
      BUSUPGR: rsp_tid = BUSUPGR;
      FLUSH:   rsp_tid = FLUSH;
      default: rsp_tid = NOOP;
    endcase
  end
  assign bcast_flag = state == SB_BCAST;
  assign bcast_bus = bcast_flag ? pkt : '0;
  assign rsp_flag = state == SB_RESP;
  assign rsp_bus = rsp_flag ? pack_pkt(PID_W'(req_id), rsp_tid, addr, rsp_data) : '0;
  assign rsp_shared = rsp_flag && req_tid == BUSRD && shared_seen;
endmodule

// File: tb/tb_mesi_snoop_bus.sv
// tb_mesi_snoop_bus: directed and randomized checks of mesi_snoop_bus against a transaction-level model
module tb_mesi_snoop_bus;
  import mesi_pkg::*;
  localparam int N = 4;
  localparam int SW = 2;
  logic clk = 1'b0;
  logic resetn;
  logic [N-1:0] req_flag, req_gnt, snp_flag;
  logic [N-1:0][BUS_W-1:0] req_bus, snp_bus;
  logic bcast_flag, rsp_flag, rsp_shared;
  logic [BUS_W-1:0] bcast_bus, rsp_bus;
  int checks = 0;
  int fails = 0;
  logic [7:0] mm [16];
  int mptr;
  int w;
  logic [3:0] m;
  logic [2:0] tids [6];
  logic [2:0] stids [4];
  int sc;

  always #5 clk = ~clk;

  mesi_snoop_bus #(.N_CORES(N), .SNOOP_WIN(SW)) dut (
    .clk(clk), .resetn(resetn),
    .req_flag(req_flag), .req_bus(req_bus), .req_gnt(req_gnt),
    .bcast_flag(bcast_flag), .bcast_bus(bcast_bus),
    .snp_flag(snp_flag), .snp_bus(snp_bus),
    .rsp_flag(rsp_flag), .rsp_bus(rsp_bus), .rsp_shared(rsp_shared)
  );

  function automatic logic [BUS_W-1:0] pk(input int pid, input logic [2:0] tid, input logic [3:0] a,
                                          input logic [7:0] d);
    return {2'(pid), tid, a, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mm[i] = 8'hFF;
    mptr = 0;
  endtask

  task automatic outs_zero(input string tag);
    check({tag, "_gnt"}, 32'(req_gnt), 0);
    check({tag, "_bcast_flag"}, 32'(bcast_flag), 0);
    check({tag, "_bcast_bus"}, 32'(bcast_bus), 0);
    check({tag, "_rsp_flag"}, 32'(rsp_flag), 0);
    check({tag, "_rsp_bus"}, 32'(rsp_bus), 0);
    check({tag, "_rsp_shared"}, 32'(rsp_shared), 0);
  endtask

  // serve one transaction: expected winner from the rotation rule, expected reply from the memory model
  task automatic serve(input int scr, input logic [2:0] st, input logic [7:0] sd, input bit drop,
                       output int win);
    int n, lat;
    logic [BUS_W-1:0] p, ex, msk;
    logic [2:0] t, et;
    logic [3:0] a;
    logic [7:0] ed;
    bit eff, fl, sh, esh;
    win = -1;
    for (int k = 0; k < N; k++) if (win < 0 && req_flag[(mptr + k) % N]) win = (mptr + k) % N;
    if (win < 0) return;
    n = 0;
    #1;
    while (req_gnt == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("gnt", 32'(req_gnt), 32'(1) << win);
    if (req_gnt == '0) return;
    mptr = (win + 1) % N;
    p = req_bus[win];
    t = p[TID_LSB +: 3];
    a = p[IDX_LSB +: 4];
    eff = scr >= 0 && scr != win && t != FLUSH;
    @(negedge clk);
    if (drop) req_flag[win] = 1'b0;
    #1;
    check("gnt_pulse", 32'(req_gnt), 0);
    check("bcast_flag", 32'(bcast_flag), 1);
    check("bcast_bus", 32'(bcast_bus), 32'(p));
    check("rsp_early", 32'(rsp_flag), 0);
    @(negedge clk);
    if (scr >= 0 && t != FLUSH) begin
      snp_flag[scr] = 1'b1;
      snp_bus[scr] = pk(scr, st, a, sd);
    end
    #1;
    check("bcast_len", 32'(bcast_flag), 0);
    @(negedge clk);
    snp_flag = '0;
    snp_bus = '0;
    lat = 3;
    #1;
    while (!rsp_flag && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    fl = eff && (st == FLUSH || st == FLUSHOPT);
    sh = eff && (fl || st == SHARED);
    if (t == FLUSH) mm[a] = p[7:0];
    if (eff && st == FLUSH) mm[a] = sd;
    et = NOOP;
    ed = 8'h00;
    esh = 1'b0;
    if (t == BUSRD || t == BUSRDX) begin
      et = MEMDATA;
      ed = fl ? sd : mm[a];
      esh = (t == BUSRD) && sh;
    end else if (t == BUSUPGR) et = BUSUPGR;
    else if (t == FLUSH) et = FLUSH;
    ex = {2'(win), et, a, ed};
    msk = (et == MEMDATA || et == BUSUPGR) ? '1 : ~17'h000FF;
    check("rsp_latency", lat, SW + 2);
    check("rsp_bus", 32'(rsp_bus & msk), 32'(ex & msk));
    check("rsp_shared", 32'(rsp_shared), 32'(esh));
    @(negedge clk);
    #1;
    check("rsp_len", 32'(rsp_flag), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tids = '{BUSRD, BUSRDX, BUSUPGR, FLUSH, NOOP, MEMDATA};
    stids = '{FLUSH, FLUSHOPT, SHARED, NOOP};
    resetn = 1'b0;
    req_flag = '0;
    req_bus = '0;
    snp_flag = '0;
    snp_bus = '0;
    model_reset();
    #1;
    outs_zero("reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    // 1: cold read returns reset memory contents
    req_flag[0] = 1'b1;
    req_bus[0] = pk(0, BUSRD, 4'b0001, 8'h00);
    serve(-1, NOOP, 8'h00, 1'b1, w);
    // 2: flushing sharer supplies data and updates memory
    req_flag[1] = 1'b1;
    req_bus[1] = pk(1, BUSRD, 4'b0100, 8'h00);
    serve(2, FLUSH, 8'h10, 1'b1, w);
    req_flag[3] = 1'b1;
    req_bus[3] = pk(3, BUSRD, 4'b0100, 8'h00);
    serve(-1, NOOP, 8'h00, 1'b1, w);
    // 3: all cores requesting, rotation order
    for (int c = 0; c < N; c++) begin
      req_flag[c] = 1'b1;
      req_bus[c] = pk(c, BUSRD, 4'(c + 4), 8'(c));
    end
    for (int i = 0; i < 8; i++) begin
      serve(-1, NOOP, 8'h00, i >= 4, w);
      check("rr_order", w, i % 4);
    end
    // 4: upgrade with a sharer: ack only, memory untouched
    req_flag[0] = 1'b1;
    req_bus[0] = pk(0, BUSUPGR, 4'b0011, 8'hAB);
    serve(1, SHARED, 8'h00, 1'b1, w);
    req_flag[2] = 1'b1;
    req_bus[2] = pk(2, BUSRD, 4'b0011, 8'h00);
    serve(-1, NOOP, 8'h00, 1'b1, w);
    // 5: reset during snoop abandons the transaction and restores memory
    @(negedge clk);
    req_flag[1] = 1'b1;
    req_bus[1] = pk(1, BUSRDX, 4'h5, 8'h00);
    #1;
    check("mid_gnt", 32'(req_gnt), 32'b0010);
    @(negedge clk);
    req_flag = '0;
    @(negedge clk);
    snp_flag[2] = 1'b1;
    snp_bus[2] = pk(2, FLUSH, 4'h5, 8'h55);
    resetn = 1'b0;
    #1;
    outs_zero("mid_reset");
    repeat (3) begin
      @(negedge clk);
      #1;
      check("no_rsp_in_reset", 32'(rsp_flag), 0);
    end
    snp_flag = '0;
    snp_bus = '0;
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    repeat (4) begin
      @(negedge clk);
      #1;
      check("no_rsp_after_reset", 32'(rsp_flag), 0);
    end
    req_flag[1] = 1'b1;
    req_bus[1] = pk(1, BUSRD, 4'h5, 8'h00);
    serve(-1, NOOP, 8'h00, 1'b1, w);
    req_flag[3] = 1'b1;
    req_bus[3] = pk(3, BUSRD, 4'b0100, 8'h00);
    serve(-1, NOOP, 8'h00, 1'b1, w);
    // 6: eviction writeback then read-back
    req_flag[2] = 1'b1;
    req_bus[2] = pk(2, FLUSH, 4'hF, 8'h30);
    serve(-1, NOOP, 8'h00, 1'b1, w);
    req_flag[0] = 1'b1;
    req_bus[0] = pk(0, BUSRD, 4'hF, 8'h00);
    serve(-1, NOOP, 8'h00, 1'b1, w);
    // randomized traffic with overlapping requesters and random snoop replies
    for (int r = 0; r < 60; r++) begin
      if (req_flag == '0) begin
        m = 4'($urandom_range(1, 15));
        for (int c = 0; c < N; c++) begin
          if (m[c]) begin
            req_flag[c] = 1'b1;
            req_bus[c] = pk(c, tids[$urandom_range(0, 5)], 4'($urandom_range(0, 15)), 8'($urandom));
          end
        end
      end
      sc = $urandom_range(0, 4);
      if (sc == 4) sc = -1;
      serve(sc, stids[$urandom_range(0, 3)], 8'($urandom), 1'b1, w);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
